disp_timing_gen: RTL

- Parallel-RGB TFT timing generator; sits directly downstream of the micro-facing register file in the display top level.
- Produces DISP_CLK, HSYNC, VSYNC, DEN and DISP_EN, and requests pixels from the upstream renderer by (x,y) coordinate.
- Drives the registered RD/GD/BD pixel bus to the panel.
- Power-sequences the panel under control of a disp_on bit from the register file.

---
 rtl/disp_pkg.sv | 42 ++++
 rtl/disp_axis_counter.sv | 64 ++++++
 rtl/disp_timing_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared types and default panel timing for the parallel-RGB TFT
// timing generator.
//   disp_state_t : panel power-sequencing states
//   rgb_t        : packed {r,g,b} pixel, 8 bits per channel
//   DEF_*        : default 480x272 panel timing
//   axis_total   : total length of one axis (active + porches + sync)
package disp_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_SYNC  = 2'd1,
    S_ON    = 2'd2,
    S_BLANK = 2'd3
  } disp_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_HACT      = 480;
  localparam int DEF_HFP       = 2;
  localparam int DEF_HSW       = 41;
  localparam int DEF_HBP       = 2;
  localparam int DEF_VACT      = 272;
  localparam int DEF_VFP       = 2;
  localparam int DEF_VSW       = 10;
  localparam int DEF_VBP       = 2;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_EN_FRAMES = 2;

  // Both axis counters are this wide; an axis total must fit in 0..1023.
  localparam int CNT_W         = 10;
  localparam int CNT_MAX_TOTAL = 1024;

  function automatic int axis_total(input int act, input int fp,
                                    input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

endpackage

// File: rtl/disp_axis_counter.sv
// disp_axis_counter: one timing axis (horizontal or vertical).
// Counts 0..TOTAL-1 when en is high, wraps to 0, and is forced to 0 by clr.
// Ports:
//   Clk, Reset : clock, synchronous active-low reset
//   clr        : hold/force the count at 0 (has priority over en)
//   en         : advance one step
//   count      : current (registered) position
//   nxt        : value count takes at the next edge
//   last       : count is TOTAL-1 (an enabled step wraps)
//   sync_n     : active-low sync decode of count
//   active     : count lies in the active region
module disp_axis_counter
  import disp_pkg::*;
#(
  parameter int ACT = DEF_HACT,
  parameter int FP  = DEF_HFP,
  parameter int SW  = DEF_HSW,
  parameter int BP  = DEF_HBP
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] nxt,
  output logic             last,
  output logic             sync_n,
  output logic             active
);

  localparam int TOTAL = axis_total(ACT, FP, SW, BP);

  // Decodes are done one bit wider so a region ending exactly at 1024
  // still compares correctly.
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   ACT_C   = (CNT_W + 1)'(ACT);
  localparam logic [CNT_W:0]   SYNC_LO = (CNT_W + 1)'(ACT + FP);
  localparam logic [CNT_W:0]   SYNC_HI = (CNT_W + 1)'(ACT + FP + SW);

  logic [CNT_W:0] cw;

  assign cw     = {1'b0, count};
  assign last   = (count == LAST_C);
  assign sync_n = !((cw >= SYNC_LO) && (cw < SYNC_HI));
  assign active = (cw < ACT_C);

  always_comb begin
    nxt = count;
    if (clr) begin
      nxt = '0;
    end else if (en) begin
      nxt = last ? '0 : count + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count <= '0;
    end else begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/disp_timing_gen.sv
// disp_timing_gen: parallel-RGB TFT timing generator with panel power
// sequencing.
// Ports:
//   Clk, Reset      : system clock, synchronous active-low reset
//   disp_on         : level request to power the panel
//   rgb_in          : {R,G,B} for the pixel at px_x/px_y
//   px_x, px_y      : requested pixel coordinate
//   px_valid        : px_x/px_y lie in the active area
//   frame_start     : one-Clk pulse after the counters wrap to (0,0)
//   status          : high while the panel is fully on (S_ON)
//   RD, GD, BD      : registered pixel data to the panel
//   DEN             : data enable
//   HSYNC, VSYNC    : active-low syncs
//   DISP_CLK        : pixel clock (falls together with data changes)
//   DISP_EN         : panel enable
//   dbg_state       : current FSM state
//
// Pixel request contract: there is no back-pressure. px_x/px_y change on a
// pixel-clock-enable edge; the renderer must hold the matching rgb_in stable
// until the next pixel-clock-enable edge, where it is sampled. That pixel
// then appears on RD/GD/BD/DEN for exactly the following pixel period.
module disp_timing_gen
  import disp_pkg::*;
#(
  parameter int HACT      = DEF_HACT,
  parameter int HFP       = DEF_HFP,
  parameter int HSW       = DEF_HSW,
  parameter int HBP       = DEF_HBP,
  parameter int VACT      = DEF_VACT,
  parameter int VFP       = DEF_VFP,
  parameter int VSW       = DEF_VSW,
  parameter int VBP       = DEF_VBP,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int EN_FRAMES = DEF_EN_FRAMES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        disp_on,
  input  logic [23:0] rgb_in,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_valid,
  output logic        frame_start,
  output logic        status,
  output logic [7:0]  RD,
  output logic [7:0]  GD,
  output logic [7:0]  BD,
  output logic        DEN,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DISP_CLK,
  output logic        DISP_EN,
  output disp_state_t dbg_state
);

  localparam int HTOTAL = axis_total(HACT, HFP, HSW, HBP);
  localparam int VTOTAL = axis_total(VACT, VFP, VSW, VBP);

  if (HTOTAL > CNT_MAX_TOTAL) begin : g_htotal_chk
    $error("disp_timing_gen: HTOTAL %0d exceeds %0d", HTOTAL, CNT_MAX_TOTAL);
  end
  if (VTOTAL > CNT_MAX_TOTAL) begin : g_vtotal_chk
    $error("disp_timing_gen: VTOTAL %0d exceeds %0d", VTOTAL, CNT_MAX_TOTAL);
  end
  if ((CLK_DIV % 2) != 0 || CLK_DIV < 2) begin : g_div_chk
    $fatal(1, "disp_timing_gen: CLK_DIV %0d must be even and >= 2", CLK_DIV);
  end

  localparam int             DW     = $clog2(CLK_DIV);
  localparam logic [DW-1:0]  D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  D_HALF = DW'(CLK_DIV / 2);
  localparam int             FW     = $clog2(EN_FRAMES + 2);
  localparam logic [FW-1:0]  EN_F   = FW'(EN_FRAMES);
  localparam logic [CNT_W:0] HACT_C = (CNT_W + 1)'(HACT);
  localparam logic [CNT_W:0] VACT_C = (CNT_W + 1)'(VACT);

  disp_state_t      state, state_nxt;
  logic [DW-1:0]    d, d_nxt;
  logic [FW-1:0]    fcnt, fcnt_post;
  logic             running, stop, pix_ce, frame_wrap, den_nxt;
  rgb_t             pix;

  logic [CNT_W-1:0] h_count, h_nxt, v_count, v_nxt;
  logic             h_last, h_sync_n, h_active;
  logic             v_last, v_sync_n, v_active;

  assign running    = (state != S_OFF);
  // Entering or staying in S_OFF clears divider and counters on this edge.
  assign stop       = (state_nxt == S_OFF);
  assign pix_ce     = running && (d == D_LAST);
  assign frame_wrap = pix_ce && h_last && v_last;
  // DEN uses the state being entered so a dropped disp_on blanks the very
  // next pixel.
  assign den_nxt    = h_active && v_active && (state_nxt == S_ON);

  disp_axis_counter #(.ACT(HACT), .FP(HFP), .SW(HSW), .BP(HBP)) u_h (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (stop),
    .en     (pix_ce),
    .count  (h_count),
    .nxt    (h_nxt),
    .last   (h_last),
    .sync_n (h_sync_n),
    .active (h_active)
  );

  disp_axis_counter #(.ACT(VACT), .FP(VFP), .SW(VSW), .BP(VBP)) u_v (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (stop),
    .en     (pix_ce && h_last),
    .count  (v_count),
    .nxt    (v_nxt),
    .last   (v_last),
    .sync_n (v_sync_n),
    .active (v_active)
  );

  always_comb begin
    d_nxt = '0;
    if (!stop && running && !pix_ce) begin
      d_nxt = d + DW'(1);
    end
  end

  // The enable check sees the frame count including a wrap on this edge.
  always_comb begin
    state_nxt = state;
    fcnt_post = frame_wrap ? fcnt + FW'(1) : fcnt;
    case (state)
      S_OFF:   if (disp_on) state_nxt = S_SYNC;
      S_SYNC: begin
        if (!disp_on) begin
          state_nxt = S_OFF;
        end else if (fcnt_post >= EN_F) begin
          state_nxt = S_ON;
        end
      end
      S_ON:    if (!disp_on) state_nxt = S_BLANK;
      S_BLANK: if (frame_wrap) state_nxt = S_OFF;
      default: state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= S_OFF;
      d           <= '0;
      fcnt        <= '0;
      DISP_CLK    <= 1'b0;
      HSYNC       <= 1'b1;
      VSYNC       <= 1'b1;
      DEN         <= 1'b0;
      pix         <= '0;
      DISP_EN     <= 1'b0;
      px_valid    <= 1'b0;
      frame_start <= 1'b0;
      status      <= 1'b0;
    end else begin
      state       <= state_nxt;
      d           <= d_nxt;
      fcnt        <= (state_nxt == S_SYNC) ? fcnt_post : '0;
      frame_start <= frame_wrap;
      status      <= (state_nxt == S_ON);
      DISP_EN     <= (state_nxt == S_ON) || (state_nxt == S_BLANK);
      px_valid    <= !stop && ({1'b0, h_nxt} < HACT_C) && ({1'b0, v_nxt} < VACT_C);
      if (stop) begin
        DISP_CLK <= 1'b0;
        HSYNC    <= 1'b1;
        VSYNC    <= 1'b1;
        DEN      <= 1'b0;
        pix      <= '0;
      end else begin
        // Looking at d_nxt makes DISP_CLK fall on the edge where d wraps.
        DISP_CLK <= (d_nxt >= D_HALF);
        if (pix_ce) begin
          HSYNC <= h_sync_n;
          VSYNC <= v_sync_n;
          DEN   <= den_nxt;
          pix   <= den_nxt ? rgb_t'(rgb_in) : '0;
        end
      end
    end
  end

  // The counters are registers, so they double as the registered request.
  assign px_x      = h_count;
  assign px_y      = v_count;
  assign RD        = pix.r;
  assign GD        = pix.g;
  assign BD        = pix.b;
  assign dbg_state = state;

endmodule
